// File: rtl/lpc_uart_tx.sv
// Transmit half of the LPC-to-UART bridge: THR byte FIFO feeding an 8N1
// serializer (LSB first), plus LSR THRE/TEMT status and a sticky overrun flag.
module lpc_uart_tx #(
  parameter int DIVISOR = 286,
  parameter int FIFO_AW = 4
) (
  input  logic               lpc_clk,
  input  logic               lpc_rst,
  input  logic               wr_stb,
  input  logic [7:0]         wr_data,
  input  logic               ovr_clr,
  output logic               uart_tx,
  output logic               thre,
  output logic               temt,
  output logic               overrun,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int CW    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int DEPTH = 2 ** FIFO_AW;

  localparam logic [CW-1:0]      CNT_MAX   = CW'(DIVISOR - 1);
  localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
  localparam logic [FIFO_AW:0]   LVL_DEPTH = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [CW-1:0]      baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shifter;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               bit_done;
  logic               fifo_empty;
  logic               pop;
  logic               push;
  logic               drop;

  // A pop is only ever issued with data present: from IDLE, or at the very
  // last cycle of a stop bit so the next frame follows with no gap.
  assign bit_done   = (baud_cnt == CNT_MAX);
  assign fifo_empty = (fifo_level == '0);
  assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));
  assign push       = wr_stb && ((fifo_level != LVL_DEPTH) || pop);
  assign drop       = wr_stb && !push;
  assign thre       = fifo_empty;
  assign temt       = fifo_empty && (state == IDLE);

  always_ff @(posedge lpc_clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overrun    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      fifo_level <= fifo_level + LVL_ONE;
      else if (pop && !push) fifo_level <= fifo_level - LVL_ONE;
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          uart_tx  <= 1'b1;
          if (pop) begin
            shifter <= mem[rd_ptr];
            state   <= START;
            uart_tx <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            uart_tx  <= shifter[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shifter[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shifter <= mem[rd_ptr];
              state   <= START;
              uart_tx <= 1'b0;
            end else begin
              state   <= IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_uart_tx.sv
// Self-checking bench for lpc_uart_tx: a byte-queue/frame-timing reference
// model predicts the serial line and status outputs every clock.
module tb_lpc_uart_tx;

  localparam int DIV     = 4;
  localparam int DIV_BIG = 286;
  localparam int DEPTH   = 16;

  logic       lpc_clk = 1'b0;
  logic       lpc_rst;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       ovr_clr;
  logic       uart_tx;
  logic       thre;
  logic       temt;
  logic       overrun;
  logic [4:0] fifo_level;

  logic       big_wr_stb;
  logic [7:0] big_wr_data;
  logic       big_ovr_clr;
  logic       big_uart_tx;
  logic       big_thre;
  logic       big_temt;
  logic       big_overrun;
  logic [4:0] big_fifo_level;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending bytes, start edge of the current frame, its byte.
  logic [7:0] mq[$];
  int         cyc    = 0;
  int         fs     = -100000;
  logic [7:0] fbyte  = 8'h00;
  logic       m_ovr  = 1'b0;

  lpc_uart_tx #(.DIVISOR(DIV), .FIFO_AW(4)) dut (
    .lpc_clk    (lpc_clk),
    .lpc_rst    (lpc_rst),
    .wr_stb     (wr_stb),
    .wr_data    (wr_data),
    .ovr_clr    (ovr_clr),
    .uart_tx    (uart_tx),
    .thre       (thre),
    .temt       (temt),
    .overrun    (overrun),
    .fifo_level (fifo_level)
  );

  lpc_uart_tx #(.DIVISOR(DIV_BIG), .FIFO_AW(4)) dut_big (
    .lpc_clk    (lpc_clk),
    .lpc_rst    (lpc_rst),
    .wr_stb     (big_wr_stb),
    .wr_data    (big_wr_data),
    .ovr_clr    (big_ovr_clr),
    .uart_tx    (big_uart_tx),
    .thre       (big_thre),
    .temt       (big_temt),
    .overrun    (big_overrun),
    .fifo_level (big_fifo_level)
  );

  always #5 lpc_clk = ~lpc_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic exp_tx();
    int b;
    if (cyc >= fs && cyc < fs + 10 * DIV) begin
      b = (cyc - fs) / DIV;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return fbyte[b - 1];
    end
    return 1'b1;
  endfunction

  function automatic logic model_idle();
    return (mq.size() == 0) && (cyc >= fs + 10 * DIV);
  endfunction

  task automatic modelReset();
    mq.delete();
    fs    = -100000;
    m_ovr = 1'b0;
  endtask

  task automatic modelEdge(input logic w, input logic [7:0] d, input logic c);
    cyc++;
    if (mq.size() > 0 && cyc >= fs + 10 * DIV) begin
      fbyte = mq.pop_front();
      fs    = cyc;
    end
    if (w && mq.size() < DEPTH) mq.push_back(d);
    if (w && mq.size() >= DEPTH && !(mq.size() == DEPTH && mq[DEPTH-1] === d && 1'b0)) begin
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("uart_tx", 32'(uart_tx), 32'(exp_tx()));
    checkVal("thre", 32'(thre), 32'(mq.size() == 0));
    checkVal("temt", 32'(temt), 32'(model_idle()));
    checkVal("overrun", 32'(overrun), 32'(m_ovr));
    checkVal("fifo_level", 32'(fifo_level), 32'(mq.size()));
  endtask

  // One clock of stimulus: drive, let the edge happen, advance the model, check.
  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic c);
    logic accepted;
    wr_stb  = w;
    wr_data = d;
    ovr_clr = c;
    @(posedge lpc_clk);
    cyc++;
    if (mq.size() > 0 && cyc >= fs + 10 * DIV) begin
      fbyte = mq.pop_front();
      fs    = cyc;
    end
    accepted = w && (mq.size() < DEPTH);
    if (accepted) mq.push_back(d);
    if (w && !accepted) m_ovr = 1'b1;
    else if (c)         m_ovr = 1'b0;
    #1;
    wr_stb  = 1'b0;
    ovr_clr = 1'b0;
    checkOutput();
  endtask

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while (!model_idle() && n < max) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      n++;
    end
    checkVal(tag, 32'(temt), 32'(1));
  endtask

  initial begin
    int low_cnt;
    int n;
    lpc_rst     = 1'b0;
    wr_stb      = 1'b0;
    wr_data     = 8'h00;
    ovr_clr     = 1'b0;
    big_wr_stb  = 1'b0;
    big_wr_data = 8'h00;
    big_ovr_clr = 1'b0;

    #12;
    checkOutput();
    checkVal("big_reset_tx", 32'(big_uart_tx), 32'(1));
    lpc_rst = 1'b1;

    $display("[TB] single byte 0x5A");
    applyStimulus(1'b1, 8'h5A, 1'b0);
    for (int k = 1; k <= 45; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      if (k == 1)  checkVal("t1_start_bit", 32'(uart_tx), 32'(0));
      if (k == 40) checkVal("t1_temt_busy", 32'(temt), 32'(0));
      if (k == 41) checkVal("t1_temt_idle", 32'(temt), 32'(1));
    end

    $display("[TB] back-to-back 0x5A 0xA5");
    applyStimulus(1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b1, 8'hA5, 1'b0);
    drain("t2_drain", 200);

    $display("[TB] FIFO flood and overrun");
    for (int i = 0; i < 18; i++) applyStimulus(1'b1, 8'(i * 17 + 3), 1'b0);
    checkVal("t3_level_full", 32'(fifo_level), 32'(16));
    checkVal("t3_overrun_set", 32'(overrun), 32'(1));
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkVal("t4_clear", 32'(overrun), 32'(0));
    applyStimulus(1'b1, 8'hEE, 1'b1);
    checkVal("t4_set_wins", 32'(overrun), 32'(1));
    applyStimulus(1'b0, 8'h00, 1'b1);
    drain("t3_drain", 1000);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 8'h00, 1'b0);
    checkVal("t5_mid_frame_low", 32'(uart_tx), 32'(0));
    #2;
    lpc_rst = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(posedge lpc_clk);
    #3;
    lpc_rst = 1'b1;
    applyStimulus(1'b1, 8'h3C, 1'b0);
    drain("t5_drain", 200);

    $display("[TB] default divisor, byte 0x00");
    big_wr_stb  = 1'b1;
    big_wr_data = 8'h00;
    @(posedge lpc_clk);
    #1;
    big_wr_stb = 1'b0;
    n = 0;
    while (big_uart_tx !== 1'b0 && n < 5) begin
      @(posedge lpc_clk);
      #1;
      n++;
    end
    checkVal("t6_start_seen", 32'(big_uart_tx), 32'(0));
    low_cnt = 0;
    while (big_uart_tx === 1'b0 && low_cnt < 3000) begin
      low_cnt++;
      @(posedge lpc_clk);
      #1;
    end
    checkVal("t6_low_len", 32'(low_cnt), 32'(9 * DIV_BIG));
    checkVal("t6_stop_high", 32'(big_uart_tx), 32'(1));
    repeat (300) @(posedge lpc_clk);
    #1;
    checkVal("t6_temt", 32'(big_temt), 32'(1));

    $display("[TB] randomized traffic");
    for (int i = 0; i < 700; i++)
      applyStimulus(($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 15) == 0));
    drain("rand_drain", 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
